// File: rtl/multi_channel_pattern_out_pkg.sv
// Shared encodings for the multi-channel pattern generator: command codes,
// parser states, control-byte bit positions and a header validity helper.
// Optional build macro: MULTI_CHANNEL_PATTERN_OUT_CHECKSUM_EN (adds S_CSUM).
package multi_channel_pattern_out_pkg;

    // Header byte command field [7:6]
    typedef enum logic [1:0] {
        CMD_WRITE    = 2'b00,
        CMD_COMMIT   = 2'b01,
        CMD_STOP     = 2'b10,
        CMD_STOP_ALL = 2'b11
    } cmd_e;

    // Packet parser states
    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_PAT   = 3'd1,
        S_DIV   = 3'd2,
        S_CTRL  = 3'd3,
`ifdef MULTI_CHANNEL_PATTERN_OUT_CHECKSUM_EN
        S_CSUM  = 3'd4,
`endif
        S_APPLY = 3'd5
    } state_e;

    // Header byte layout
    typedef struct packed {
        cmd_e       cmd;
        logic [5:0] idx;
    } hdr_t;

    localparam int unsigned IDX_W         = 6;
    // Control byte bit positions
    localparam int unsigned CTRL_MODE_BIT = 0;   // 0 one-shot, 1 repeat
    localparam int unsigned CTRL_EN_BIT   = 1;   // start on COMMIT

    // COMMIT/STOP_ALL ignore the index; WRITE/STOP need an existing channel
    function automatic logic idx_ok(input cmd_e cmd, input logic [IDX_W-1:0] idx,
                                    input int unsigned ch_num);
        return (cmd == CMD_COMMIT) || (cmd == CMD_STOP_ALL) || (32'(idx) < ch_num);
    endfunction

endpackage

// File: rtl/multi_channel_pattern_out_if.sv
// Received-byte stream bundle (byte + one-cycle strobe) feeding the generator.
interface multi_channel_pattern_out_if;
    logic [7:0] data;
    logic       rx_done_tick;

    modport master (output data, output rx_done_tick);
    modport slave  (input  data, input  rx_done_tick);
endinterface

// File: rtl/multi_channel_pattern_out_pattern_channel.sv
// One output channel: latches its active pattern/divider/mode on start and
// shifts the pattern out LSB first, each bit held DIV+1 cycles.
module pattern_channel #(
    parameter int unsigned DATA_BIT = 32,
    parameter int unsigned DIV_BIT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [DATA_BIT-1:0] i_pattern,
    input  logic [DIV_BIT-1:0]  i_div,
    input  logic                i_mode,
    output logic                o_serial,
    output logic                o_busy,
    output logic                o_done_tick
);
    localparam int unsigned BIT_W = $clog2(DATA_BIT);

    logic [DATA_BIT-1:0] r_shift;
    logic [DIV_BIT-1:0]  r_div;
    logic                r_mode;
    logic [DIV_BIT-1:0]  r_div_cnt;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic                r_serial;
    logic                r_busy;
    logic                r_done;

    logic [DATA_BIT-1:0] w_rot;
    logic                w_bit_end;
    logic                w_last_bit;

    // Rotating the pattern returns it to its original value after DATA_BIT
    // bits, so repeat mode needs no separate reload.
    assign w_rot      = {r_shift[0], r_shift[DATA_BIT-1:1]};
    assign w_bit_end  = (r_div_cnt == r_div);
    assign w_last_bit = (r_bit_cnt == BIT_W'(DATA_BIT - 1));

    // Bit timing, shifting and end-of-pattern handling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_div     <= '0;
            r_mode    <= 1'b0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_serial  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_shift   <= i_pattern;
                r_div     <= i_div;
                r_mode    <= i_mode;
                r_div_cnt <= '0;
                r_bit_cnt <= '0;
                r_serial  <= i_pattern[0];
                r_busy    <= 1'b1;
            end else if (i_stop) begin
                r_div_cnt <= '0;
                r_bit_cnt <= '0;
                r_serial  <= 1'b0;
                r_busy    <= 1'b0;
            end else if (r_busy) begin
                if (w_bit_end) begin
                    r_div_cnt <= '0;
                    if (w_last_bit && !r_mode) begin
                        r_bit_cnt <= '0;
                        r_serial  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BIT_W'(1);
                        r_shift   <= w_rot;
                        r_serial  <= w_rot[0];
                    end
                end else begin
                    r_div_cnt <= r_div_cnt + DIV_BIT'(1);
                end
            end
        end
    end

    assign o_serial    = r_serial;
    assign o_busy      = r_busy;
    assign o_done_tick = r_done;

endmodule

// File: rtl/multi_channel_pattern_out.sv
// Multi-channel serial pattern generator: parses byte packets into per-channel
// shadow registers and starts/stops channels on COMMIT/STOP commands.
// Optional build macro: MULTI_CHANNEL_PATTERN_OUT_CHECKSUM_EN appends an XOR
// checksum byte to every packet.
module multi_channel_pattern_out
    import multi_channel_pattern_out_pkg::*;
#(
    parameter int unsigned CH_NUM   = 16,
    parameter int unsigned DATA_BIT = 32,
    parameter int unsigned DIV_BIT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_data,
    input  logic              i_rx_done_tick,
    output logic [CH_NUM-1:0] o_serial_out,
    output logic [CH_NUM-1:0] o_busy,
    output logic [CH_NUM-1:0] o_done_tick,
    output logic              o_cmd_done_tick,
    output logic              o_err
);
    localparam int unsigned PAT_BYTES = DATA_BIT / 8;
    localparam int unsigned DIV_BYTES = DIV_BIT / 8;
    localparam int unsigned CNT_W     = 8;

    state_e               r_state;
    state_e               w_state_next;
    cmd_e                 r_cmd;
    logic [IDX_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_cnt;
    logic [DATA_BIT-1:0]  r_pat_buf;
    logic [DIV_BIT-1:0]   r_div_buf;
    logic                 r_mode_buf;
    logic                 r_en_buf;
    logic                 r_ok;
    logic                 r_cmd_done;
    logic                 r_err;
`ifdef MULTI_CHANNEL_PATTERN_OUT_CHECKSUM_EN
    logic [7:0]           r_csum;
`endif

    logic [DATA_BIT-1:0]  r_sh_pat [CH_NUM];
    logic [DIV_BIT-1:0]   r_sh_div [CH_NUM];
    logic [CH_NUM-1:0]    r_sh_mode;
    logic [CH_NUM-1:0]    r_sh_en;

    hdr_t                 w_hdr;
    logic                 w_hdr_take;
    logic                 w_last_pat;
    logic                 w_last_div;
    logic                 w_enter_apply;
    logic                 w_ok_next;
    logic                 w_apply_ok;
    logic                 w_commit;
    logic                 w_write;
    logic [CH_NUM-1:0]    w_start;
    logic [CH_NUM-1:0]    w_stop;

    // A header may arrive in S_HDR or during the single S_APPLY cycle
    assign w_hdr      = hdr_t'(i_data);
    assign w_hdr_take = i_rx_done_tick && ((r_state == S_HDR) || (r_state == S_APPLY));
    assign w_last_pat = (r_cnt == CNT_W'(PAT_BYTES - 1));
    assign w_last_div = (r_cnt == CNT_W'(DIV_BYTES - 1));

    // Parser state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_HDR;
        else     r_state <= w_state_next;
    end

    // Parser next state; validity of the packet is decided on the last byte
    always_comb begin
        w_state_next  = r_state;
        w_enter_apply = 1'b0;
        w_ok_next     = 1'b0;
        case (r_state)
            S_HDR, S_APPLY: begin
                if (r_state == S_APPLY) w_state_next = S_HDR;
                if (i_rx_done_tick) begin
                    if (w_hdr.cmd == CMD_WRITE) begin
                        w_state_next = S_PAT;
                    end else begin
`ifdef MULTI_CHANNEL_PATTERN_OUT_CHECKSUM_EN
                        w_state_next  = S_CSUM;
`else
                        w_state_next  = S_APPLY;
                        w_enter_apply = 1'b1;
                        w_ok_next     = idx_ok(w_hdr.cmd, w_hdr.idx, CH_NUM);
`endif
                    end
                end
            end
            S_PAT: begin
                if (i_rx_done_tick && w_last_pat) w_state_next = S_DIV;
            end
            S_DIV: begin
                if (i_rx_done_tick && w_last_div) w_state_next = S_CTRL;
            end
            S_CTRL: begin
                if (i_rx_done_tick) begin
`ifdef MULTI_CHANNEL_PATTERN_OUT_CHECKSUM_EN
                    w_state_next  = S_CSUM;
`else
                    w_state_next  = S_APPLY;
                    w_enter_apply = 1'b1;
                    w_ok_next     = idx_ok(r_cmd, r_idx, CH_NUM);
`endif
                end
            end
`ifdef MULTI_CHANNEL_PATTERN_OUT_CHECKSUM_EN
            S_CSUM: begin
                if (i_rx_done_tick) begin
                    w_state_next  = S_APPLY;
                    w_enter_apply = 1'b1;
                    w_ok_next     = idx_ok(r_cmd, r_idx, CH_NUM) && (r_csum == i_data);
                end
            end
`endif
            default: w_state_next = S_HDR;
        endcase
    end

    // Packet field capture and accept/reject pulses (high during S_APPLY)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd      <= CMD_WRITE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_pat_buf  <= '0;
            r_div_buf  <= '0;
            r_mode_buf <= 1'b0;
            r_en_buf   <= 1'b0;
            r_ok       <= 1'b0;
            r_cmd_done <= 1'b0;
            r_err      <= 1'b0;
`ifdef MULTI_CHANNEL_PATTERN_OUT_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_cmd_done <= w_enter_apply && w_ok_next;
            r_err      <= w_enter_apply && !w_ok_next;
            if (w_enter_apply) r_ok <= w_ok_next;
            if (w_hdr_take) begin
                r_cmd <= w_hdr.cmd;
                r_idx <= w_hdr.idx;
                r_cnt <= '0;
`ifdef MULTI_CHANNEL_PATTERN_OUT_CHECKSUM_EN
                r_csum <= i_data;
`endif
            end else if (i_rx_done_tick) begin
`ifdef MULTI_CHANNEL_PATTERN_OUT_CHECKSUM_EN
                r_csum <= r_csum ^ i_data;
`endif
                case (r_state)
                    S_PAT: begin
                        r_pat_buf <= (r_pat_buf >> 8) | (DATA_BIT'(i_data) << (DATA_BIT - 8));
                        r_cnt     <= w_last_pat ? '0 : r_cnt + CNT_W'(1);
                    end
                    S_DIV: begin
                        r_div_buf <= (r_div_buf >> 8) | (DIV_BIT'(i_data) << (DIV_BIT - 8));
                        r_cnt     <= w_last_div ? '0 : r_cnt + CNT_W'(1);
                    end
                    S_CTRL: begin
                        r_mode_buf <= i_data[CTRL_MODE_BIT];
                        r_en_buf   <= i_data[CTRL_EN_BIT];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_apply_ok = (r_state == S_APPLY) && r_ok;
    assign w_commit   = w_apply_ok && (r_cmd == CMD_COMMIT);
    assign w_write    = w_apply_ok && (r_cmd == CMD_WRITE);

    // Per-channel start/stop strobes, all issued in the same S_APPLY cycle
    always_comb begin
        w_start = '0;
        w_stop  = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            w_start[i] = w_commit && r_sh_en[i];
            w_stop[i]  = w_apply_ok && ((r_cmd == CMD_STOP_ALL) ||
                         ((r_cmd == CMD_STOP) && (r_idx == IDX_W'(i))));
        end
    end

    // Shadow registers: only the indexed channel changes on an accepted WRITE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH_NUM; i++) begin
                r_sh_pat[i] <= '0;
                r_sh_div[i] <= '0;
            end
            r_sh_mode <= '0;
            r_sh_en   <= '0;
        end else if (w_write) begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    r_sh_pat[i]  <= r_pat_buf;
                    r_sh_div[i]  <= r_div_buf;
                    r_sh_mode[i] <= r_mode_buf;
                    r_sh_en[i]   <= r_en_buf;
                end
            end
        end
    end

    // Channel shifters; each latches its shadow values as active on start
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
        pattern_channel #(
            .DATA_BIT (DATA_BIT),
            .DIV_BIT  (DIV_BIT)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .i_start     (w_start[gi]),
            .i_stop      (w_stop[gi]),
            .i_pattern   (r_sh_pat[gi]),
            .i_div       (r_sh_div[gi]),
            .i_mode      (r_sh_mode[gi]),
            .o_serial    (o_serial_out[gi]),
            .o_busy      (o_busy[gi]),
            .o_done_tick (o_done_tick[gi])
        );
    end

    assign o_cmd_done_tick = r_cmd_done;
    assign o_err           = r_err;

endmodule

// File: tb/tb_multi_channel_pattern_out.sv
// Directed bench for multi_channel_pattern_out (CH_NUM=16, DATA_BIT=32, DIV_BIT=16).
// Honours MULTI_CHANNEL_PATTERN_OUT_CHECKSUM_EN when defined.
module tb_multi_channel_pattern_out;
    import multi_channel_pattern_out_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] serial_out;
    logic [15:0] busy;
    logic [15:0] done_tick;
    logic        cmd_done_tick;
    logic        err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  csum;
    logic [31:0] pat;

    multi_channel_pattern_out_if rx_if ();

    multi_channel_pattern_out #(.CH_NUM(16), .DATA_BIT(32), .DIV_BIT(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_data          (rx_if.data),
        .i_rx_done_tick  (rx_if.rx_done_tick),
        .o_serial_out    (serial_out),
        .o_busy          (busy),
        .o_done_tick     (done_tick),
        .o_cmd_done_tick (cmd_done_tick),
        .o_err           (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one byte strobe for exactly one cycle; returns #1 after that edge
    task automatic send_byte(input logic [7:0] b);
        rx_if.data         = b;
        rx_if.rx_done_tick = 1'b1;
        csum               = csum ^ b;
        @(posedge clk);
        #1;
        rx_if.rx_done_tick = 1'b0;
    endtask

    // Closes a packet and checks the accept/reject pulse during S_APPLY
    task automatic finish_pkt(input logic exp_ok);
`ifdef MULTI_CHANNEL_PATTERN_OUT_CHECKSUM_EN
        logic [7:0] c;
        c = csum;
        send_byte(c);
`endif
        check("cmd_done", 64'(cmd_done_tick), 64'(exp_ok));
        check("err", 64'(err), 64'(!exp_ok));
    endtask

    task automatic write_body(input logic [5:0] ch, input logic [31:0] p,
                              input logic [15:0] d, input logic [7:0] ctrl);
        csum = 8'h00;
        send_byte({CMD_WRITE, ch});
        for (int k = 0; k < 4; k++) send_byte(p[8*k +: 8]);
        for (int k = 0; k < 2; k++) send_byte(d[8*k +: 8]);
        send_byte(ctrl);
    endtask

    task automatic send_write(input logic [5:0] ch, input logic [31:0] p,
                              input logic [15:0] d, input logic [7:0] ctrl,
                              input logic exp_ok);
        write_body(ch, p, d, ctrl);
        finish_pkt(exp_ok);
    endtask

    task automatic send_cmd(input cmd_e cmd, input logic [5:0] ch, input logic exp_ok);
        csum = 8'h00;
        send_byte({cmd, ch});
        finish_pkt(exp_ok);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst                = 1'b1;
        rx_if.data         = 8'h00;
        rx_if.rx_done_tick = 1'b0;
        csum               = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_serial", 64'(serial_out), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done_tick), 64'h0);
        check("rst_cmd_err", 64'({cmd_done_tick, err}), 64'h0);
        rst = 1'b0;
        step();

        // ch0 one-shot 0xA5, two cycles per bit, single done tick
        pat = 32'h0000_00A5;
        send_write(6'd0, pat, 16'd1, 8'h02, 1'b1);
        send_cmd(CMD_COMMIT, 6'd0, 1'b1);
        check("t1_pre_start", 64'(serial_out[0]), 64'h0);
        for (int b = 0; b < 32; b++) begin
            for (int h = 0; h < 2; h++) begin
                step();
                check("t1_bit", 64'(serial_out[0]), 64'(pat[b]));
                check("t1_busy", 64'(busy[0]), 64'h1);
                check("t1_no_done", 64'(done_tick[0]), 64'h0);
            end
        end
        step();
        check("t1_end_serial", 64'(serial_out[0]), 64'h0);
        check("t1_end_busy", 64'(busy[0]), 64'h0);
        check("t1_done", 64'(done_tick[0]), 64'h1);
        step();
        check("t1_done_once", 64'(done_tick[0]), 64'h0);

        // ch1 repeat 0x80000001, one cycle per bit, then STOP
        pat = 32'h8000_0001;
        send_write(6'd0, 32'h0, 16'd0, 8'h00, 1'b1);
        send_write(6'd1, pat, 16'd0, 8'h03, 1'b1);
        send_cmd(CMD_COMMIT, 6'd0, 1'b1);
        for (int c = 0; c < 70; c++) begin
            step();
            check("t2_bit", 64'(serial_out[1]), 64'(pat[c % 32]));
            check("t2_busy", 64'(busy[1]), 64'h1);
            check("t2_no_done", 64'(done_tick[1]), 64'h0);
        end
        send_cmd(CMD_STOP, 6'd1, 1'b1);
        check("t2_stop_busy_hold", 64'(busy[1]), 64'h1);
        step();
        check("t2_stop_serial", 64'(serial_out[1]), 64'h0);
        check("t2_stop_busy", 64'(busy[1]), 64'h0);
        check("t2_stop_no_done", 64'(done_tick[1]), 64'h0);
        for (int c = 0; c < 40; c++) begin
            step();
            check("t2_stays_low", 64'(serial_out[1]), 64'h0);
        end

        // ch2 (div 3, repeat) and ch5 (div 0, one-shot) start together
        send_write(6'd2, 32'h0000_0001, 16'd3, 8'h03, 1'b1);
        send_write(6'd5, 32'h0000_0003, 16'd0, 8'h02, 1'b1);
        send_cmd(CMD_COMMIT, 6'd0, 1'b1);
        check("t3_pre", 64'({serial_out[5], serial_out[2], busy[5], busy[2]}), 64'h0);
        step();
        check("t3_same_start", 64'({serial_out[5], serial_out[2]}), 64'h3);
        check("t3_busy", 64'({busy[5], busy[2]}), 64'h3);
        repeat (9) step();
        check("t3_ch2_bit2", 64'(serial_out[2]), 64'h0);
        // COMMIT to a busy channel restarts it from bit0
        send_cmd(CMD_COMMIT, 6'd0, 1'b1);
        check("t3_restart_pre", 64'(serial_out[2]), 64'h0);
        step();
        check("t3_restart", 64'(serial_out[2]), 64'h1);

        // Out-of-range index rejected, then a valid packet is accepted
        send_write(6'd63, 32'hFFFF_FFFF, 16'd0, 8'h03, 1'b0);
        send_cmd(CMD_STOP, 6'd20, 1'b0);
        check("t4_stop_bad_busy", 64'(busy[2]), 64'h1);
        send_cmd(CMD_STOP_ALL, 6'd0, 1'b1);
        step();
        check("t4_stop_all", 64'(busy), 64'h0);
        send_cmd(CMD_COMMIT, 6'd0, 1'b1);
        step();
        check("t4_shadows", 64'(busy), 64'h0026);
        check("t4_ch15_idle", 64'(serial_out[15]), 64'h0);

`ifdef MULTI_CHANNEL_PATTERN_OUT_CHECKSUM_EN
        // Corrupt checksum discards the packet
        write_body(6'd4, 32'h0000_0001, 16'd0, 8'h02);
        send_byte(csum ^ 8'h5A);
        check("t6_csum_err", 64'(err), 64'h1);
        check("t6_csum_no_done", 64'(cmd_done_tick), 64'h0);
        send_cmd(CMD_COMMIT, 6'd0, 1'b1);
        step();
        check("t6_csum_no_update", 64'(busy[4]), 64'h0);
`endif

        // Reset mid-packet and mid-shift clears everything at once
        csum = 8'h00;
        send_byte({CMD_WRITE, 6'd3});
        send_byte(8'h11);
        check("t5_pre_rst_busy", 64'(|busy), 64'h1);
        rst = 1'b1;
        #1;
        check("t5_rst_serial", 64'(serial_out), 64'h0);
        check("t5_rst_busy", 64'(busy), 64'h0);
        check("t5_rst_done", 64'({done_tick, cmd_done_tick, err}), 64'h0);
        step();
        rst = 1'b0;
        step();
        send_cmd(CMD_COMMIT, 6'd0, 1'b1);
        step();
        check("t5_shadow_cleared", 64'(busy), 64'h0);
        send_write(6'd3, 32'h0000_000F, 16'd0, 8'h02, 1'b1);
        send_cmd(CMD_COMMIT, 6'd0, 1'b1);
        step();
        check("t5_after_rst_busy", 64'(busy), 64'h0008);
        check("t5_after_rst_serial", 64'(serial_out), 64'h0008);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
